// File: rtl/booth_mac_seq.sv
// rtl/booth_mac_seq.sv - operand sequencer and signed dot-product accumulator for a Booth multiplier
// Optional saturation of the accumulator: BOOTH_MAC_SAT_EN.
module booth_mac_seq #(
   parameter int W     = 4,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic               in_last,
   output logic               mul_start,
   output logic [W-1:0]       mul_a,
   output logic [W-1:0]       mul_b,
   input  logic [2*W-1:0]     mul_p,
   input  logic               mul_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [CNT_W-1:0]   out_count,
   output logic               out_ovf
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT, S_HOLD} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t             state_q;
   logic               in_ready_q;
   logic               mul_start_q;
   logic [W-1:0]       mul_a_q;
   logic [W-1:0]       mul_b_q;
   logic               out_valid_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               last_q;
   logic [ACC_W-1:0]   p_ext;
   logic [ACC_W-1:0]   sum;
   logic               add_ovf;

   always_comb begin
      p_ext   = ACC_W'($signed(mul_p));
      sum     = acc_q + p_ext;
      // Signed overflow: operands agree in sign, result disagrees.
      add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BOOTH_MAC_SAT_EN
      if (add_ovf) begin
         acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         acc_d = sum;
      end
`else
      acc_d = sum;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  mul_a_q     <= in_a;
                  mul_b_q     <= in_b;
                  last_q      <= in_last;
                  in_ready_q  <= 1'b0;
                  mul_start_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mul_start_q <= 1'b0;
               state_q     <= S_ARM;
            end
            // The multiplier's ready is still high from idle here; skip it.
            S_ARM: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_ready) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  ovf_q <= ovf_q | add_ovf;
                  if (last_q) begin
                     out_valid_q <= 1'b1;
                     state_q     <= S_HOLD;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign mul_start = mul_start_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_booth_mac_seq.sv
// tb/tb_booth_mac_seq.sv - directed self-checking bench for booth_mac_seq with a behavioural multiplier
// Expected overflow result follows BOOTH_MAC_SAT_EN.
module tb_booth_mac_seq;
   localparam int W     = 4;
   localparam int ACC_W = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic             in_last = 1'b0;
   logic             mul_start;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic [2*W-1:0]   mul_p;
   logic             mul_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   logic             model_rst = 1'b1;
   logic             hold_high = 1'b0;
   logic             mrdy_q;
   int               mcnt;
   int               starts = 0;
   logic [W-1:0]     seen_a = '0;
   logic [W-1:0]     seen_b = '0;
   int               n_checks = 0;
   int               n_pass = 0;

   booth_mac_seq #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .mul_ready (mul_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // Multiplier model: ready drops after start, returns 4 cycles later.
   always @(posedge clk) begin
      if (model_rst) begin
         mrdy_q <= 1'b1;
         mcnt   <= 0;
         mul_p  <= '0;
      end else if (mul_start) begin
         mrdy_q <= 1'b0;
         mcnt   <= 4;
         mul_p  <= 8'($signed(mul_a) * $signed(mul_b));
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1) mrdy_q <= 1'b1;
      end
   end
   assign mul_ready = hold_high | mrdy_q;

   always @(posedge clk) begin
      if (!reset && mul_start) begin
         starts = starts + 1;
         seen_a = mul_a;
         seen_b = mul_b;
      end
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      check("start_latency", mul_start, 1);
   endtask

   task automatic wait_out();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic accept_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      model_rst = 1'b0;
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_mul_start", mul_start, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", $signed(out_sum), 0);
      check("rst_out_count", out_count, 0);
      check("rst_out_ovf", out_ovf, 0);

      // Single-pair burst
      send_pair(4'd5, 4'd6, 1'b1);
      wait_out();
      check("p1_starts", starts, 1);
      check("p1_mul_a", seen_a, 5);
      check("p1_mul_b", seen_b, 6);
      check("p1_sum", $signed(out_sum), 30);
      check("p1_count", out_count, 1);
      check("p1_ovf", out_ovf, 0);
      accept_out();
      check("p1_cleared_valid", out_valid, 0);
      check("p1_cleared_sum", $signed(out_sum), 0);
      check("p1_in_ready_back", in_ready, 1);

      // Three-pair burst with a long HOLD and ignored inputs
      send_pair(4'd3, 4'b1110, 1'b0);
      send_pair(4'b1000, 4'b1000, 1'b0);
      send_pair(4'd7, 4'd1, 1'b1);
      wait_out();
      check("b3_starts", starts, 4);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_a = 4'd1; in_b = 4'd1;
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_sum", $signed(out_sum), 65);
         check("hold_count", out_count, 3);
         check("hold_ovf", out_ovf, 0);
         check("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      check("hold_no_start", starts, 4);
      accept_out();
      check("b3_cleared_count", out_count, 0);

      // Overflow: 49+49+49
      send_pair(4'd7, 4'd7, 1'b0);
      send_pair(4'd7, 4'd7, 1'b0);
      send_pair(4'd7, 4'd7, 1'b1);
      wait_out();
`ifdef BOOTH_MAC_SAT_EN
      check("ovf_sum", $signed(out_sum), 127);
`else
      check("ovf_sum", $signed(out_sum), -109);
`endif
      check("ovf_flag", out_ovf, 1);
      check("ovf_count", out_count, 3);
      accept_out();
      check("ovf_flag_cleared", out_ovf, 0);

      // Reset while waiting on the multiplier
      send_pair(4'd4, 4'd4, 1'b0);
      send_pair(4'd1, 4'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_sum", $signed(out_sum), 16);
      check("pre_rst_count", out_count, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_mul_start", mul_start, 0);
      check("mid_rst_mul_a", mul_a, 0);
      check("mid_rst_mul_b", mul_b, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_sum", $signed(out_sum), 0);
      check("mid_rst_count", out_count, 0);
      repeat (8) @(negedge clk);
      check("late_ready_ignored", $signed(out_sum), 0);
      send_pair(4'd2, 4'd3, 1'b1);
      wait_out();
      check("after_rst_sum", $signed(out_sum), 6);
      check("after_rst_count", out_count, 1);
      accept_out();

      // Multiplier ready stuck high
      hold_high = 1'b1;
      send_pair(4'd1, 4'd1, 1'b0);
      send_pair(4'd1, 4'd1, 1'b1);
      wait_out();
      check("hh_sum", $signed(out_sum), 2);
      check("hh_count", out_count, 2);
      accept_out();
      hold_high = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
